// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT sequencing controller.
package fft_pkg;

   typedef logic [1:0] fsm_state_t;

   localparam fsm_state_t ST_IDLE  = 2'd0;
   localparam fsm_state_t ST_RUN   = 2'd1;
   localparam fsm_state_t ST_DRAIN = 2'd2;
   localparam fsm_state_t ST_DONE  = 2'd3;

   // Ceiling log2, evaluated at elaboration time for sizing.
   function automatic int fft_log2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Write-back delay line: carries {en, addr_a, addr_b} BF_LAT cycles,
// shifting every cycle so stalled slots appear as wb_en=0.
module fft_wb_delay #(
   parameter int BF_LAT = 2,
   parameter int AW     = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_en,
   input  logic [AW-1:0] in_addr_a,
   input  logic [AW-1:0] in_addr_b,
   output logic          out_en,
   output logic [AW-1:0] out_addr_a,
   output logic [AW-1:0] out_addr_b
);

   localparam int DW = 2 * AW + 1;

   logic [DW-1:0] dly_q [BF_LAT];
   logic [DW-1:0] dly_d [BF_LAT];

   always_comb begin
      dly_d[0] = {in_en, in_addr_a, in_addr_b};
      for (int i = 1; i < BF_LAT; i++) begin
         dly_d[i] = dly_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BF_LAT; i++) dly_q[i] <= '0;
      end else begin
         for (int i = 0; i < BF_LAT; i++) dly_q[i] <= dly_d[i];
      end
   end

   assign {out_en, out_addr_a, out_addr_b} = dly_q[BF_LAT-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Radix-2 DIT in-place FFT sequencer: butterfly addressing, twiddle index
// and write-back timing. Define FFT_SEQ_CTRL_IFFT_EN to add the inverse port.
module fft_seq_ctrl
   import fft_pkg::*;
#(
   parameter  int N      = 16,
   parameter  int BF_LAT = 2,
   localparam int AW     = fft_log2(N),
   localparam int SW     = fft_log2(AW) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stall,
`ifdef FFT_SEQ_CTRL_IFFT_EN
   input  logic          inverse,
`endif
   output logic          busy,
   output logic          done,
   output logic          bf_issue,
   output logic [AW-1:0] bf_addr_a,
   output logic [AW-1:0] bf_addr_b,
   output logic [AW-2:0] tw_addr,
   output logic [SW-1:0] stage,
   output logic          wb_en,
   output logic [AW-1:0] wb_addr_a,
   output logic [AW-1:0] wb_addr_b,
   output logic          tw_conj
);

   localparam int JW = AW - 1;
   localparam logic [JW-1:0] J_LAST = JW'(N / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(AW - 1);
   localparam logic [3:0]    D_LAST = 4'(BF_LAT - 1);

   fsm_state_t    state_q, state_d;
   logic [JW-1:0] j_q, j_d;
   logic [SW-1:0] stage_q, stage_d;
   logic [3:0]    drn_q, drn_d;

   logic          run;
   logic          issue;
   logic [AW-1:0] one_s;
   logic [JW-1:0] mask_j;
   logic [JW-1:0] pos_j;
   logic [AW-1:0] addr_a;
   logic [AW-1:0] addr_b;
   logic [SW-1:0] tw_sh;
   logic [JW-1:0] tw_k;

   assign run   = (state_q == ST_RUN);
   assign issue = run & ~stall;

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      stage_d = stage_q;
      drn_d   = drn_q;
      unique case (1'b1)
         (state_q == ST_IDLE): begin
            if (start) begin
               state_d = ST_RUN;
               j_d     = '0;
               stage_d = '0;
            end
         end
         (state_q == ST_RUN): begin
            if (!stall) begin
               if (j_q == J_LAST) begin
                  state_d = ST_DRAIN;
                  drn_d   = '0;
               end else begin
                  j_d = j_q + JW'(1);
               end
            end
         end
         (state_q == ST_DRAIN): begin
            if (drn_q == D_LAST) begin
               if (stage_q == S_LAST) begin
                  state_d = ST_DONE;
                  stage_d = '0;
               end else begin
                  state_d = ST_RUN;
                  stage_d = stage_q + SW'(1);
                  j_d     = '0;
               end
            end else begin
               drn_d = drn_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // grp*2^(s+1) is j with its low s bits cleared, shifted left once.
   always_comb begin
      one_s  = AW'(1) << stage_q;
      mask_j = JW'(one_s - AW'(1));
      pos_j  = j_q & mask_j;
      addr_a = {j_q & ~mask_j, 1'b0} | AW'(pos_j);
      addr_b = addr_a | one_s;
      tw_sh  = S_LAST - stage_q;
      tw_k   = pos_j << tw_sh;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         j_q     <= '0;
         stage_q <= '0;
         drn_q   <= '0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         stage_q <= stage_d;
         drn_q   <= drn_d;
      end
   end

`ifdef FFT_SEQ_CTRL_IFFT_EN
   logic inv_q, inv_d;

   always_comb begin
      inv_d = inv_q;
      if (state_q == ST_IDLE && start) inv_d = inverse;
   end

   always_ff @(posedge clk) begin
      if (rst) inv_q <= 1'b0;
      else     inv_q <= inv_d;
   end

   assign tw_conj = inv_q;
`else
   assign tw_conj = 1'b0;
`endif

   assign busy      = run | (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);
   assign bf_issue  = issue;
   assign bf_addr_a = run ? addr_a : '0;
   assign bf_addr_b = run ? addr_b : '0;
   assign tw_addr   = run ? tw_k : '0;
   assign stage     = stage_q;

   fft_wb_delay #(
      .BF_LAT (BF_LAT),
      .AW     (AW)
   ) u_wb_delay (
      .clk        (clk),
      .rst        (rst),
      .in_en      (issue),
      .in_addr_a  (issue ? addr_a : '0),
      .in_addr_b  (issue ? addr_b : '0),
      .out_en     (wb_en),
      .out_addr_a (wb_addr_a),
      .out_addr_b (wb_addr_b)
   );

endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 16: FFT points; power of 2, range 4..1024.
REQ-002 SHALL have parameter BF_LAT, default 2: butterfly pipeline latency in cycles, range 1..8.
REQ-003 SHALL derive AW = log2(N) and SW = log2(AW)+1 as localparams.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin one in-place transform.
REQ-007 stall  in  1  holds butterfly issue.
REQ-008 busy  out  1  transform in progress.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 bf_issue  out  1  issue strobe to the butterfly unit.
REQ-011 bf_addr_a, bf_addr_b  out  AW each  operand addresses in the sample RAM.
REQ-012 tw_addr  out  AW-1  twiddle ROM index k of W_N^k.
REQ-013 stage  out  SW  current stage, 0..AW-1.
REQ-014 wb_en  out  1  write-back strobe, BF_LAT cycles after the matching bf_issue.
REQ-015 wb_addr_a, wb_addr_b  out  AW each  write-back addresses, delayed copy of the issue addresses.
REQ-016 tw_conj  out  1  conjugate-twiddle flag for the inverse transform.

Function
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE->RUN SHALL occur on start=1; the FSM SHALL clear the stage and butterfly index j.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 RUN with stall=0 SHALL assert bf_issue and then increment j; stall=1 SHALL deassert bf_issue and hold j and the addresses.
REQ-021 Radix-2 DIT addressing for stage s and index j: pos = j mod 2^s, grp = j >> s, bf_addr_a = grp*2^(s+1)+pos, bf_addr_b = bf_addr_a+2^s, tw_addr = pos << (AW-1-s).
REQ-022 After the issue with j = N/2-1, RUN->DRAIN; DRAIN SHALL last exactly BF_LAT cycles so that the last write-back of the stage completes.
REQ-023 At DRAIN end: if s < AW-1 go to RUN with s+1 and j=0; otherwise go to DONE.
REQ-024 DONE SHALL pulse done for one cycle and then go to IDLE.
REQ-025 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE and DONE.
REQ-026 The write-back delay line SHALL shift every cycle regardless of stall; a stalled cycle carries wb_en=0.
REQ-027 Cycle count with no stall, start sampled at cycle 0: first issue at cycle 1, done at cycle 1 + AW*(N/2+BF_LAT); each stalled cycle adds one cycle.
REQ-028 In IDLE and DONE, bf_issue and wb_en SHALL be 0.

Reset
REQ-029 rst SHALL force IDLE and clear j, stage and the delay line; all outputs SHALL be 0 in the next cycle.
REQ-030 rst during RUN or DRAIN SHALL abort the transform with no further wb_en and no done pulse.
REQ-031 rst SHALL take priority over start in the same cycle.

Configuration
REQ-032 Macro FFT_SEQ_CTRL_IFFT_EN defined: an input port inverse (1 bit) SHALL exist and be latched at start; tw_conj SHALL equal the latched value until the next start.
REQ-033 Macro undefined: the inverse port SHALL be absent and tw_conj SHALL be tied to 0.

Structure
REQ-034 Package fft_pkg SHALL hold the FSM state typedef and the log2 helper function.
REQ-035 The write-back delay line SHALL be sub-module fft_wb_delay, with parameters BF_LAT and AW, carrying {en, addr_a, addr_b}.

Verification (N=8, BF_LAT=2)
REQ-036 Start, no stall -> stage0 pairs (0,1)(2,3)(4,5)(6,7) tw 0,0,0,0; stage1 (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2; stage2 (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3.
REQ-037 Start at cycle 0 -> issues at cycles 1-4, 7-10 and 13-16; wb_en at 3-6, 9-12 and 15-18; done at cycle 19; busy at cycles 1-18.
REQ-038 stall=1 at cycles 2-3 -> pair (2,3) issued at cycle 4, done at cycle 21, wb_addr sequence unchanged.
REQ-039 rst at cycle 8 -> from cycle 9 busy=0 and wb_en=0 with no done; a start at cycle 10 restarts stage0 at (0,1).
REQ-040 start repeated at cycle 5 -> ignored, with no effect on the address sequence or on the timing.
REQ-041 With FFT_SEQ_CTRL_IFFT_EN, inverse=1 at start -> tw_conj=1 during the whole transform; inverse toggled mid-run -> tw_conj unchanged.
